// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for the 4x4-output convolution engine: walks a tiles_h x tiles_w map in
// raster order, running load -> start -> wait-for-done -> four-row write-back per tile.
module conv_tile_scheduler #(
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 512,
   parameter int TO_W    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_tiles_h,
   input  logic [CNT_W-1:0] cmd_tiles_w,
   output logic             load_req,
   input  logic             load_ack,
   output logic [CNT_W-1:0] tile_row,
   output logic [CNT_W-1:0] tile_col,
   output logic             conv_start,
   input  logic             conv_done,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [1:0]       wb_row,
   output logic             busy,
   output logic             irq_done,
   output logic             err
);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, WB, NEXT, FIN} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] tiles_h, tiles_w, tiles_h_next, tiles_w_next;
   logic [CNT_W-1:0] tile_row_next, tile_col_next;
   logic [TO_W-1:0]  to_cnt, to_cnt_next;
   logic [1:0]       wb_row_next;
   logic             err_next, done_q, done_edge;
   logic             cmd_ready_next, load_req_next, conv_start_next;
   logic             wb_valid_next, busy_next, irq_done_next;

   // Only a fresh rising edge counts; done_q resets high so a stale level is never an edge.
   assign done_edge = conv_done && !done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tiles_h    <= '0;
         tiles_w    <= '0;
         tile_row   <= '0;
         tile_col   <= '0;
         to_cnt     <= '0;
         wb_row     <= 2'd0;
         err        <= 1'b0;
         done_q     <= 1'b1;
         cmd_ready  <= 1'b1;
         load_req   <= 1'b0;
         conv_start <= 1'b0;
         wb_valid   <= 1'b0;
         busy       <= 1'b0;
         irq_done   <= 1'b0;
      end else begin
         state      <= state_next;
         tiles_h    <= tiles_h_next;
         tiles_w    <= tiles_w_next;
         tile_row   <= tile_row_next;
         tile_col   <= tile_col_next;
         to_cnt     <= to_cnt_next;
         wb_row     <= wb_row_next;
         err        <= err_next;
         done_q     <= conv_done;
         cmd_ready  <= cmd_ready_next;
         load_req   <= load_req_next;
         conv_start <= conv_start_next;
         wb_valid   <= wb_valid_next;
         busy       <= busy_next;
         irq_done   <= irq_done_next;
      end
   end

   always_comb begin
      state_next    = state;
      tiles_h_next  = tiles_h;
      tiles_w_next  = tiles_w;
      tile_row_next = tile_row;
      tile_col_next = tile_col;
      to_cnt_next   = to_cnt;
      wb_row_next   = wb_row;
      err_next      = err;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               tiles_h_next  = cmd_tiles_h;
               tiles_w_next  = cmd_tiles_w;
               tile_row_next = '0;
               tile_col_next = '0;
               err_next      = 1'b0;
               if (cmd_tiles_h == '0 || cmd_tiles_w == '0) begin
                  err_next   = 1'b1;
                  state_next = FIN;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            if (load_ack) begin
               to_cnt_next = '0;
               state_next  = START;
            end
         end
         START: begin
            to_cnt_next = to_cnt + TO_W'(1);
            state_next  = WAIT;
         end
         WAIT: begin
            to_cnt_next = to_cnt + TO_W'(1);
            if (done_edge) begin
               wb_row_next = 2'd0;
               state_next  = WB;
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
               err_next   = 1'b1;
               state_next = FIN;
            end
         end
         WB: begin
            if (wb_ready) begin
               wb_row_next = wb_row + 2'd1;
               if (wb_row == 2'd3) state_next = NEXT;
            end
         end
         NEXT: begin
            if (tile_col < tiles_w - CNT_W'(1)) begin
               tile_col_next = tile_col + CNT_W'(1);
               state_next    = LOAD;
            end else begin
               tile_col_next = '0;
               if (tile_row < tiles_h - CNT_W'(1)) begin
                  tile_row_next = tile_row + CNT_W'(1);
                  state_next    = LOAD;
               end else begin
                  state_next = FIN;
               end
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered, so they are decoded from the state being entered.
   always_comb begin
      cmd_ready_next  = (state_next == IDLE);
      busy_next       = (state_next != IDLE);
      load_req_next   = (state_next == LOAD);
      conv_start_next = (state_next == START);
      wb_valid_next   = (state_next == WB);
      irq_done_next   = (state_next == FIN);
   end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Randomised bench for conv_tile_scheduler: engine/loader/sink models drive the DUT, a monitor
// logs events, and each test compares the log against a raster-order reference model.
module tb_conv_tile_scheduler;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 512;
   localparam int TO_W    = 10;
   localparam logic [16:0] RST_VEC = 17'h10000;

   typedef int iq_t[$];

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_tiles_h = '0;
   logic [CNT_W-1:0] cmd_tiles_w = '0;
   logic             load_req;
   logic             load_ack = 1'b0;
   logic [CNT_W-1:0] tile_row, tile_col;
   logic             conv_start;
   logic             conv_done = 1'b1;
   logic             wb_valid;
   logic             wb_ready = 1'b1;
   logic [1:0]       wb_row;
   logic             busy, irq_done, err;

   conv_tile_scheduler #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_tiles_h(cmd_tiles_h), .cmd_tiles_w(cmd_tiles_w),
      .load_req(load_req), .load_ack(load_ack), .tile_row(tile_row), .tile_col(tile_col),
      .conv_start(conv_start), .conv_done(conv_done), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_row(wb_row), .busy(busy), .irq_done(irq_done), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // environment knobs
   int ld_dly = 5, done_dly = 211, fall_dly = 3, rdy_mode = 0;
   bit eng_never = 1'b0, spur_ack = 1'b0;
   int ld_cnt = 0, rdy_ph = 0, since = 0;
   bit running = 1'b0;

   // event log
   int start_cyc[$], start_tile[$], wb_cyc[$], wb_rowq[$], wb_tile[$];
   int wv_cyc[$], wv_row[$], wv_rdy[$];
   int rise_cyc[$], wbst_cyc[$], ldr_cyc[$], irq_cyc[$], irq_err[$];
   bit prev_done = 1'b1, prev_wv = 1'b0, prev_lr = 1'b0;

   // Loader, engine and sink models; inputs change 2 time units after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (load_ack) load_ack = 1'b0;
         else if (load_req) begin
            if (ld_cnt >= ld_dly) begin load_ack = 1'b1; ld_cnt = 0; end
            else ld_cnt++;
         end else begin
            ld_cnt = 0;
            if (spur_ack && $urandom_range(0, 5) == 0) load_ack = 1'b1;
         end
         if (conv_start) begin running = 1'b1; since = 0; end
         else if (running) since++;
         if (running && since == fall_dly) conv_done = 1'b0;
         if (running && !eng_never && since == done_dly) begin conv_done = 1'b1; running = 1'b0; end
         case (rdy_mode)
            0: wb_ready = 1'b1;
            1: begin wb_ready = (rdy_ph == 2); rdy_ph = (rdy_ph + 1) % 3; end
            2: wb_ready = 1'($urandom_range(0, 1));
            default: wb_ready = (wb_row < 2'd2);
         endcase
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (conv_start) begin
            start_cyc.push_back(cyc);
            start_tile.push_back(int'(tile_row) * 16 + int'(tile_col));
         end
         if (wb_valid) begin
            wv_cyc.push_back(cyc); wv_row.push_back(int'(wb_row)); wv_rdy.push_back(int'(wb_ready));
         end
         if (wb_valid && wb_ready) begin
            wb_cyc.push_back(cyc); wb_rowq.push_back(int'(wb_row));
            wb_tile.push_back(int'(tile_row) * 16 + int'(tile_col));
         end
         if (conv_done && !prev_done) rise_cyc.push_back(cyc);
         if (wb_valid && !prev_wv) wbst_cyc.push_back(cyc);
         if (load_req && !prev_lr) ldr_cyc.push_back(cyc);
         if (irq_done) begin irq_cyc.push_back(cyc); irq_err.push_back(int'(err)); end
         prev_done = conv_done; prev_wv = wb_valid; prev_lr = load_req;
      end
   end

   // Reference model: tiles in raster order, column fastest, encoded row*16+col.
   function automatic iq_t exp_tiles(input int h, input int w);
      iq_t q;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) q.push_back(r * 16 + c);
      return q;
   endfunction

   function automatic logic [16:0] outs();
      return {cmd_ready, load_req, conv_start, wb_valid, wb_row, tile_row, tile_col, busy, irq_done, err};
   endfunction

   task automatic clear_rec();
      start_cyc.delete(); start_tile.delete(); wb_cyc.delete(); wb_rowq.delete(); wb_tile.delete();
      wv_cyc.delete(); wv_row.delete(); wv_rdy.delete(); rise_cyc.delete(); wbst_cyc.delete();
      ldr_cyc.delete(); irq_cyc.delete(); irq_err.delete();
   endtask

   task automatic issue_cmd(input int h, input int w, output int acc_cyc);
      @(posedge clk); #2;
      cmd_valid = 1'b1; cmd_tiles_h = CNT_W'(h); cmd_tiles_w = CNT_W'(w);
      @(posedge clk); #2;
      cmd_valid = 1'b0; acc_cyc = cyc;
      $display("cmd h=%0d w=%0d issued, accept cycle %0d", h, w, acc_cyc);
   endtask

   task automatic wait_irq(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget && irq_cyc.size() < n; i++) begin @(negedge clk); #1; end
      ok = (irq_cyc.size() >= n);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [16:0] obs;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 obs = outs();
      n_cmp++;
      if (obs !== RST_VEC) begin n_bad++; $display("FAIL reset_values: got %h required %h", obs, RST_VEC); end
      @(posedge clk); #2 rst_n = 1'b1;
      $display("reset released at cycle %0d", cyc);
   endtask

   task automatic test_single();
      int acc; bit ok;
      clear_rec(); ld_dly = 5; done_dly = 211; rdy_mode = 0; eng_never = 1'b0; spur_ack = 1'b0;
      issue_cmd(1, 1, acc);
      wait_irq(1, 1000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_irq_wait: got timeout required irq_done"); end
      n_cmp++; if (start_cyc.size() != 1) begin n_bad++; $display("FAIL single_starts: got %0d required 1", start_cyc.size()); end
      n_cmp++; if (wb_cyc.size() != 4) begin n_bad++; $display("FAIL single_beats: got %0d required 4", wb_cyc.size()); end
      for (int i = 0; i < wb_cyc.size(); i++) begin
         n_cmp++; if (wb_rowq[i] != i) begin n_bad++; $display("FAIL single_row[%0d]: got %0d required %0d", i, wb_rowq[i], i); end
         n_cmp++; if (wb_cyc[i] != wb_cyc[0] + i) begin n_bad++; $display("FAIL single_beat_cycle[%0d]: got %0d required %0d", i, wb_cyc[i], wb_cyc[0] + i); end
      end
      n_cmp++;
      if (irq_err.size() != 1 || irq_err[0] != 0) begin
         n_bad++; $display("FAIL single_irq_err: got %0d irqs err=%0d required 1 irq err=0", irq_err.size(), err);
      end
   endtask

   task automatic test_raster();
      int acc; bit ok; iq_t m;
      clear_rec(); ld_dly = 5; done_dly = 211; rdy_mode = 0;
      m = exp_tiles(2, 3);
      issue_cmd(2, 3, acc);
      wait_irq(1, 3000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL raster_irq_wait: got timeout required irq_done"); end
      n_cmp++; if (start_tile.size() != m.size()) begin n_bad++; $display("FAIL raster_starts: got %0d required %0d", start_tile.size(), m.size()); end
      for (int i = 0; i < m.size() && i < start_tile.size(); i++) begin
         n_cmp++; if (start_tile[i] != m[i]) begin n_bad++; $display("FAIL raster_tile[%0d]: got %0h required %0h", i, start_tile[i], m[i]); end
      end
      n_cmp++; if (wb_cyc.size() != 4 * m.size()) begin n_bad++; $display("FAIL raster_beats: got %0d required %0d", wb_cyc.size(), 4 * m.size()); end
      for (int i = 0; i < wb_cyc.size() && i < 4 * m.size(); i++) begin
         n_cmp++;
         if (wb_tile[i] != m[i / 4] || wb_rowq[i] != i % 4) begin
            n_bad++; $display("FAIL raster_beat[%0d]: got tile %0h row %0d required tile %0h row %0d", i, wb_tile[i], wb_rowq[i], m[i / 4], i % 4);
         end
      end
      n_cmp++; if (rise_cyc.size() != m.size() || wbst_cyc.size() != m.size()) begin
         n_bad++; $display("FAIL raster_edges: got %0d rises %0d wb starts required %0d", rise_cyc.size(), wbst_cyc.size(), m.size());
      end
      for (int i = 0; i < rise_cyc.size() && i < wbst_cyc.size(); i++) begin
         n_cmp++; if (wbst_cyc[i] != rise_cyc[i] + 1) begin n_bad++; $display("FAIL raster_wb_after_edge[%0d]: got %0d required %0d", i, wbst_cyc[i], rise_cyc[i] + 1); end
      end
      n_cmp++; if (irq_err.size() != 1 || irq_err[0] != 0) begin n_bad++; $display("FAIL raster_irq: got %0d irqs required 1 with err=0", irq_err.size()); end
   endtask

   task automatic test_wb_stall();
      int acc, c; bit ok; iq_t m;
      clear_rec(); ld_dly = 2; done_dly = 40; rdy_mode = 1; rdy_ph = 0;
      m = exp_tiles(1, 2);
      issue_cmd(1, 2, acc);
      wait_irq(1, 1000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_irq_wait: got timeout required irq_done"); end
      n_cmp++; if (wb_cyc.size() != 8) begin n_bad++; $display("FAIL stall_beats: got %0d required 8", wb_cyc.size()); end
      for (int i = 0; i < wb_cyc.size() && i < 8; i++) begin
         n_cmp++;
         if (wb_tile[i] != m[i / 4] || wb_rowq[i] != i % 4) begin
            n_bad++; $display("FAIL stall_beat[%0d]: got tile %0h row %0d required tile %0h row %0d", i, wb_tile[i], wb_rowq[i], m[i / 4], i % 4);
         end
      end
      for (int j = 0; j + 1 < wv_cyc.size(); j++) begin
         if (wv_rdy[j] == 0) begin
            n_cmp++;
            if (wv_cyc[j + 1] != wv_cyc[j] + 1 || wv_row[j + 1] != wv_row[j]) begin
               n_bad++; $display("FAIL stall_hold@%0d: got row %0d at cycle %0d required row %0d at cycle %0d", wv_cyc[j], wv_row[j + 1], wv_cyc[j + 1], wv_row[j], wv_cyc[j] + 1);
            end
         end
      end
      if (wb_cyc.size() == 8 && ldr_cyc.size() == 2 && irq_cyc.size() == 1) begin
         c = wb_cyc[3];
         n_cmp++; if (ldr_cyc[1] != c + 2) begin n_bad++; $display("FAIL stall_next_load: got %0d required %0d", ldr_cyc[1], c + 2); end
         c = wb_cyc[7];
         n_cmp++; if (irq_cyc[0] != c + 2) begin n_bad++; $display("FAIL stall_next_fin: got %0d required %0d", irq_cyc[0], c + 2); end
      end else begin
         n_cmp++; n_bad++;
         $display("FAIL stall_event_counts: got %0d beats %0d loads %0d irqs required 8/2/1", wb_cyc.size(), ldr_cyc.size(), irq_cyc.size());
      end
      rdy_mode = 0;
   endtask

   task automatic test_timeout();
      int acc; bit ok;
      clear_rec(); ld_dly = 3; eng_never = 1'b1;
      issue_cmd(2, 2, acc);
      wait_irq(1, 2000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL timeout_irq_wait: got timeout required irq_done"); end
      n_cmp++; if (irq_err.size() != 1 || irq_err[0] != 1) begin n_bad++; $display("FAIL timeout_err: got %0d irqs err=%0d required 1 irq err=1", irq_err.size(), err); end
      n_cmp++;
      if (start_cyc.size() != 1 || irq_cyc.size() != 1 || irq_cyc[0] - start_cyc[0] != TIMEOUT) begin
         n_bad++; $display("FAIL timeout_latency: got %0d starts %0d irqs delta %0d required 1/1/%0d", start_cyc.size(), irq_cyc.size(),
                           (start_cyc.size() > 0 && irq_cyc.size() > 0) ? irq_cyc[0] - start_cyc[0] : -1, TIMEOUT);
      end
      n_cmp++; if (wb_cyc.size() != 0) begin n_bad++; $display("FAIL timeout_no_wb: got %0d beats required 0", wb_cyc.size()); end
      n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: got ready=%0b busy=%0b required 1/0", cmd_ready, busy); end
      eng_never = 1'b0; done_dly = 30; clear_rec();
      issue_cmd(1, 1, acc);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_clear: got %0b required 0", err); end
      wait_irq(1, 1000, ok);
      n_cmp++; if (!ok || irq_err[0] != 0 || wb_cyc.size() != 4) begin
         n_bad++; $display("FAIL timeout_recover: got ok=%0b beats %0d required ok=1 err=0 beats 4", ok, wb_cyc.size());
      end
   endtask

   task automatic test_zero();
      int acc;
      clear_rec();
      issue_cmd(3, 0, acc);
      repeat (4) @(negedge clk);
      n_cmp++; if (irq_cyc.size() != 1 || irq_cyc[0] != acc + 1) begin
         n_bad++; $display("FAIL zero_irq: got %0d irqs at %0d required 1 at %0d", irq_cyc.size(), irq_cyc.size() > 0 ? irq_cyc[0] : -1, acc + 1);
      end
      n_cmp++; if (irq_err.size() != 1 || irq_err[0] != 1) begin n_bad++; $display("FAIL zero_err: got err=%0b required 1", err); end
      n_cmp++; if (ldr_cyc.size() != 0 || start_cyc.size() != 0) begin
         n_bad++; $display("FAIL zero_no_work: got %0d loads %0d starts required 0/0", ldr_cyc.size(), start_cyc.size());
      end
   endtask

   task automatic test_random();
      int acc, h, w; bit ok; iq_t m;
      spur_ack = 1'b1; rdy_mode = 2;
      for (int it = 0; it < 6; it++) begin
         clear_rec();
         h = int'($urandom_range(1, 3)); w = int'($urandom_range(1, 3));
         ld_dly = int'($urandom_range(0, 4)); done_dly = int'($urandom_range(8, 30));
         m = exp_tiles(h, w);
         issue_cmd(h, w, acc);
         wait_irq(1, 3000, ok);
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_irq_wait: got timeout required irq_done", it); end
         n_cmp++; if (start_tile.size() != m.size() || wb_cyc.size() != 4 * m.size()) begin
            n_bad++; $display("FAIL rand%0d_counts: got %0d starts %0d beats required %0d/%0d", it, start_tile.size(), wb_cyc.size(), m.size(), 4 * m.size());
         end
         for (int i = 0; i < start_tile.size() && i < m.size(); i++) begin
            n_cmp++; if (start_tile[i] != m[i]) begin n_bad++; $display("FAIL rand%0d_tile[%0d]: got %0h required %0h", it, i, start_tile[i], m[i]); end
         end
         for (int i = 0; i < wb_cyc.size() && i < 4 * m.size(); i++) begin
            n_cmp++;
            if (wb_tile[i] != m[i / 4] || wb_rowq[i] != i % 4) begin
               n_bad++; $display("FAIL rand%0d_beat[%0d]: got tile %0h row %0d required tile %0h row %0d", it, i, wb_tile[i], wb_rowq[i], m[i / 4], i % 4);
            end
         end
         for (int i = 0; i < rise_cyc.size() && i < wbst_cyc.size(); i++) begin
            n_cmp++; if (wbst_cyc[i] != rise_cyc[i] + 1) begin n_bad++; $display("FAIL rand%0d_edge[%0d]: got %0d required %0d", it, i, wbst_cyc[i], rise_cyc[i] + 1); end
         end
         n_cmp++; if (irq_err.size() != 1 || irq_err[0] != 0) begin n_bad++; $display("FAIL rand%0d_irq: got %0d irqs required 1 with err=0", it, irq_err.size()); end
      end
      spur_ack = 1'b0; rdy_mode = 0;
   endtask

   task automatic test_reset_mid_wb();
      int acc; bit found; logic [16:0] obs;
      clear_rec(); ld_dly = 2; done_dly = 20; rdy_mode = 3; found = 1'b0;
      issue_cmd(1, 1, acc);
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk); #1;
         found = (wb_valid === 1'b1 && wb_row === 2'd2);
      end
      n_cmp++; if (!found) begin n_bad++; $display("FAIL rstwb_reach_row2: got no stalled row-2 beat required one"); end
      #1 rst_n = 1'b0;
      #1 obs = outs();
      n_cmp++; if (obs !== RST_VEC) begin n_bad++; $display("FAIL rstwb_async_values: got %h required %h", obs, RST_VEC); end
      rdy_mode = 0;
      repeat (3) @(negedge clk);
      n_cmp++; if (wb_cyc.size() != 2) begin n_bad++; $display("FAIL rstwb_beats: got %0d required 2", wb_cyc.size()); end
      @(posedge clk); #2 rst_n = 1'b1; running = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_raster();
      test_wb_stall();
      test_timeout();
      test_zero();
      test_random();
      test_reset_mid_wb();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
